// File: rtl/axi4_lite_pkg.sv
// Shared response codes, handshake FSM encodings and a width helper for the AXI4-Lite register slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage: byte-strobe merge, W1C clear/set priority and RO read mux.
// Commit lands on the enable edge; combinational read port, no backpressure.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int                   DATA_W   = 32,
  parameter int                   NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0]  W1C_MASK = '0,
  localparam int                  IDX_W    = clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [DATA_W-1:0]          wr_dat_i,
  input  logic [DATA_W/8-1:0]        wr_strb_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic [DATA_W-1:0]          rd_dat_o,
  input  logic [NUM_REGS*DATA_W-1:0] hw_data_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set_i,
  output logic [NUM_REGS*DATA_W-1:0] reg_data_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] hw_data_a, hw_set_a;
  logic [DATA_W-1:0]               lane_mask;
  logic                            hit;

  assign hw_data_a = hw_data_i;
  assign hw_set_a  = hw_set_i;

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < DATA_W/8; b++) lane_mask[b*8 +: 8] = {8{wr_strb_i[b]}};
  end

  // Set is OR-ed in after the clear, so a same-cycle iHW_SET bit survives a write-1 clear.
  always_comb begin
    regs_d = regs_q;
    hit    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit = wr_en_i && (wr_idx_i == IDX_W'(i));
      if (hit && !W1C_MASK[i]) regs_d[i] = (regs_q[i] & ~lane_mask) | (wr_dat_i & lane_mask);
      if (hit && W1C_MASK[i])  regs_d[i] = regs_q[i] & ~(wr_dat_i & lane_mask);
      regs_d[i] = regs_d[i] | (hw_set_a[i] & {DATA_W{W1C_MASK[i]}});
      if (RO_MASK[i]) regs_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  assign rd_dat_o   = RO_MASK[rd_idx_i] ? hw_data_a[rd_idx_i] : regs_q[rd_idx_i];
  assign reg_data_o = regs_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite CSR slave: AW/W captured independently, SLVERR on out-of-range words.
// B/R registered on the final handshake edge and held until BREADY/RREADY.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       s_AWVALID,
  output logic                       s_AWREADY,
  input  logic [ADDR_W-1:0]          s_AWADDR,
  input  logic [2:0]                 s_AWPROT,
  input  logic                       s_WVALID,
  output logic                       s_WREADY,
  input  logic [DATA_W-1:0]          s_WDATA,
  input  logic [DATA_W/8-1:0]        s_WSTRB,
  output logic                       s_BVALID,
  input  logic                       s_BREADY,
  output logic [1:0]                 s_BRESP,
  input  logic                       s_ARVALID,
  output logic                       s_ARREADY,
  input  logic [ADDR_W-1:0]          s_ARADDR,
  input  logic [2:0]                 s_ARPROT,
  output logic                       s_RVALID,
  input  logic                       s_RREADY,
  output logic [DATA_W-1:0]          s_RDATA,
  output logic [1:0]                 s_RRESP,
  input  logic [NUM_REGS*DATA_W-1:0] iHW_DATA,
  input  logic [NUM_REGS*DATA_W-1:0] iHW_SET,
  output logic [NUM_REGS*DATA_W-1:0] oREG_DATA,
  output logic [NUM_REGS-1:0]        oWR_PULSE
);

  localparam int                LSB        = clog2(DATA_W/8);
  localparam int                IDX_W      = clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  wr_state_e wstate_q, wstate_d;
  rd_state_e rstate_q, rstate_d;

  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;

  logic                aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0]   cm_addr, cm_word, ar_word;
  logic [DATA_W-1:0]   cm_data, bank_rd;
  logic [DATA_W/8-1:0] cm_strb;
  logic                cm_in_range, ar_in_range;
  logic [IDX_W-1:0]    cm_idx, ar_idx;
  logic                unused_prot;

  assign unused_prot = ^{s_AWPROT, s_ARPROT};

  assign aw_hs = s_AWVALID && awready_q;
  assign w_hs  = s_WVALID && wready_q;
  assign ar_hs = s_ARVALID && arready_q;

  // The half accepted earlier comes from its latch, the half arriving now straight off the bus.
  assign cm_addr     = (wstate_q == W_HAVE_A) ? awaddr_q : s_AWADDR;
  assign cm_data     = (wstate_q == W_HAVE_D) ? wdata_q : s_WDATA;
  assign cm_strb     = (wstate_q == W_HAVE_D) ? wstrb_q : s_WSTRB;
  assign cm_word     = cm_addr >> LSB;
  assign cm_in_range = cm_word < NUM_REGS_A;
  assign cm_idx      = cm_word[IDX_W-1:0];
  assign ar_word     = s_ARADDR >> LSB;
  assign ar_in_range = ar_word < NUM_REGS_A;
  assign ar_idx      = ar_word[IDX_W-1:0];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_A;
        else if (w_hs)     wstate_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)     wstate_d = W_RESP;
      W_HAVE_D: if (aw_hs)    wstate_d = W_RESP;
      W_RESP:   if (s_BREADY) wstate_d = W_IDLE;
      default:                wstate_d = W_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)    rstate_d = R_RESP;
      R_RESP:  if (s_RREADY) rstate_d = R_IDLE;
      default:               rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    case (wstate_q)
      W_IDLE:   commit = aw_hs && w_hs;
      W_HAVE_A: commit = w_hs;
      W_HAVE_D: commit = aw_hs;
      default:  commit = 1'b0;
    endcase
    awready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_D);
    wready_d   = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_A);
    bvalid_d   = (wstate_d == W_RESP);
    awaddr_d   = aw_hs ? s_AWADDR : awaddr_q;
    wdata_d    = w_hs ? s_WDATA : wdata_q;
    wstrb_d    = w_hs ? s_WSTRB : wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    if (commit) begin
      bresp_d = cm_in_range ? RESP_OKAY : RESP_SLVERR;
      if (cm_in_range && !RO_MASK[cm_idx]) wr_pulse_d[cm_idx] = 1'b1;
    end
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_RESP);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rdata_d = ar_in_range ? bank_rd : '0;
      rresp_d = ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axi4_lite_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK),
    .W1C_MASK (W1C_MASK)
  ) u_bank (
    .clk_i      (iCLK),
    .arst_ni    (iRST),
    .wr_en_i    (commit && cm_in_range),
    .wr_idx_i   (cm_idx),
    .wr_dat_i   (cm_data),
    .wr_strb_i  (cm_strb),
    .rd_idx_i   (ar_idx),
    .rd_dat_o   (bank_rd),
    .hw_data_i  (iHW_DATA),
    .hw_set_i   (iHW_SET),
    .reg_data_o (oREG_DATA)
  );

  assign s_AWREADY = awready_q;
  assign s_WREADY  = wready_q;
  assign s_BVALID  = bvalid_q;
  assign s_BRESP   = bresp_q;
  assign s_ARREADY = arready_q;
  assign s_RVALID  = rvalid_q;
  assign s_RDATA   = rdata_q;
  assign s_RRESP   = rresp_q;
  assign oWR_PULSE = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Randomized and directed bench for axi4_lite_reg_slave against an array-based register model.
module tb_axi4_lite_reg_slave;

  localparam int              DW  = 32;
  localparam int              NR  = 16;
  localparam logic [NR-1:0]   RO  = 16'h0001;
  localparam logic [NR-1:0]   W1C = 16'h0002;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  logic s_AWVALID = 1'b0, s_AWREADY, s_WVALID = 1'b0, s_WREADY;
  logic [31:0] s_AWADDR = '0, s_ARADDR = '0, s_WDATA = '0, s_RDATA;
  logic [2:0]  s_AWPROT = '0, s_ARPROT = '0;
  logic [3:0]  s_WSTRB = '0;
  logic s_BVALID, s_BREADY = 1'b0, s_ARVALID = 1'b0, s_ARREADY, s_RVALID, s_RREADY = 1'b0;
  logic [1:0]  s_BRESP, s_RRESP;
  logic [NR*DW-1:0] iHW_DATA = '0, iHW_SET = '0, oREG_DATA;
  logic [NR-1:0]    oWR_PULSE;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mdl [NR];

  always #5 iCLK = ~iCLK;

  axi4_lite_reg_slave #(
    .DATA_W(DW), .ADDR_W(32), .NUM_REGS(NR), .RO_MASK(RO), .W1C_MASK(W1C)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(s_AWPROT),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .iHW_DATA(iHW_DATA), .iHW_SET(iHW_SET), .oREG_DATA(oREG_DATA), .oWR_PULSE(oWR_PULSE)
  );

  task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) if (!RO[i]) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic ref_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    if (idx >= NR)   begin d = 32'h0; r = 2'b10; end
    else if (RO[idx]) begin d = iHW_DATA[idx*DW +: DW]; r = 2'b00; end
    else             begin d = mdl[idx]; r = 2'b00; end
  endtask

  task automatic ref_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    resp = (idx >= NR) ? 2'b10 : 2'b00;
    pulse = '0;
    if (idx < NR && !RO[idx]) begin
      pulse[idx] = 1'b1;
      if (W1C[idx]) mdl[idx] = mdl[idx] & ~(data & m);
      else          mdl[idx] = (mdl[idx] & ~m) | (data & m);
    end
    for (int i = 0; i < NR; i++) if (W1C[i]) mdl[i] = mdl[i] | iHW_SET[i*DW +: DW];
  endtask

  // lead > 0: W is presented lead cycles before AW; lead < 0: AW leads by -lead cycles.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdly);
    bit aw_done, w_done, hs_aw, hs_w;
    int c;
    logic [1:0] exp_r;
    logic [NR-1:0] exp_p;
    aw_done = 0; w_done = 0; c = 0;
    s_AWADDR = addr; s_WDATA = data; s_WSTRB = strb;
    while (!(aw_done && w_done) && c < 30) begin
      s_AWVALID = !aw_done && (c >= ((lead > 0) ? lead : 0));
      s_WVALID  = !w_done && (c >= ((lead < 0) ? -lead : 0));
      hs_aw = s_AWVALID && s_AWREADY;
      hs_w  = s_WVALID && s_WREADY;
      tick();
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      c++;
      if (!(aw_done && w_done)) begin
        if (aw_done) check("awready_after_aw", s_AWREADY, 0);
        if (w_done)  check("wready_after_w", s_WREADY, 0);
        check("no_early_pulse", oWR_PULSE, 0);
        check("no_early_commit", oREG_DATA, exp_flat());
      end
    end
    s_AWVALID = 1'b0; s_WVALID = 1'b0;
    if (!(aw_done && w_done)) check("write_timeout", 0, 1);
    ref_write(int'(addr >> 2), data, strb, exp_r, exp_p);
    check("bvalid", s_BVALID, 1);
    check("bresp", s_BRESP, exp_r);
    check("wr_pulse", oWR_PULSE, exp_p);
    check("reg_data", oREG_DATA, exp_flat());
    for (int i = 0; i < bdly; i++) begin
      tick();
      check("bvalid_hold", s_BVALID, 1);
      check("bresp_hold", s_BRESP, exp_r);
      check("aw_w_ready_hold", {s_AWREADY, s_WREADY}, 2'b00);
      check("pulse_single", oWR_PULSE, 0);
    end
    s_BREADY = 1'b1;
    tick();
    s_BREADY = 1'b0;
    check("bvalid_clear", s_BVALID, 0);
    check("aw_w_ready_back", {s_AWREADY, s_WREADY}, 2'b11);
    check("pulse_clear", oWR_PULSE, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly);
    int c;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    s_ARADDR = addr; s_ARVALID = 1'b1; c = 0;
    while (!s_ARREADY && c < 20) begin tick(); c++; end
    if (!s_ARREADY) check("ar_timeout", 0, 1);
    ref_read(int'(addr >> 2), exp_d, exp_r);
    tick();
    s_ARVALID = 1'b0;
    iHW_DATA[31:0] = $urandom();
    check("rvalid", s_RVALID, 1);
    check("arready_drop", s_ARREADY, 0);
    check("rdata", s_RDATA, exp_d);
    check("rresp", s_RRESP, exp_r);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check("rvalid_hold", s_RVALID, 1);
      check("rdata_hold", s_RDATA, exp_d);
    end
    s_RREADY = 1'b1;
    tick();
    s_RREADY = 1'b0;
    check("rvalid_clear", s_RVALID, 0);
    check("arready_back", s_ARREADY, 1);
    check("rdata_keep", s_RDATA, exp_d);
  endtask

  initial begin
    logic [31:0] old_v, new_v, a;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_ready", {s_AWREADY, s_WREADY, s_ARREADY}, 0);
    check("rst_valid", {s_BVALID, s_RVALID}, 0);
    check("rst_resp_rdata", {s_BRESP, s_RRESP, s_RDATA}, 0);
    check("rst_regs", oREG_DATA, 0);
    check("rst_pulse", oWR_PULSE, 0);
    iRST = 1'b1;
    check("ready_before_edge", {s_AWREADY, s_WREADY, s_ARREADY}, 0);
    tick();
    check("ready_after_edge", {s_AWREADY, s_WREADY, s_ARREADY}, 3'b111);

    iHW_DATA[31:0] = 32'h1234;
    axi_write(32'h20, 32'd8080, 4'b1111, 0, 0);
    axi_read(32'h20, 0);
    axi_write(32'h20, 32'hAABBCCDD, 4'b0101, 0, 1);
    axi_read(32'h20, 2);
    axi_write(32'h0C, 32'd106, 4'b1111, 2, 0);
    axi_read(32'h0C, 0);
    axi_write(32'h40, 32'hDEADBEEF, 4'b1111, -1, 0);
    axi_read(32'h40, 1);
    axi_write(32'h24, 32'h55, 4'b0000, 0, 0);

    iHW_SET[32+3] = 1'b1;
    tick();
    iHW_SET = '0;
    mdl[1] = mdl[1] | 32'h8;
    check("w1c_set", oREG_DATA, exp_flat());
    axi_read(32'h04, 0);
    axi_write(32'h04, 32'h8, 4'b1111, 0, 0);
    axi_read(32'h04, 0);
    iHW_SET[32+3] = 1'b1;
    axi_write(32'h04, 32'h8, 4'b1111, 0, 0);
    iHW_SET = '0;
    axi_read(32'h04, 0);
    iHW_DATA[31:0] = 32'h1234;
    axi_read(32'h00, 0);
    iHW_DATA[31:0] = 32'h1234;
    axi_write(32'h00, 32'hFFFF_FFFF, 4'b1111, 1, 0);
    axi_read(32'h00, 0);

    // Read and write commit to the same register on the same edge.
    old_v = mdl[2];
    new_v = $urandom();
    s_AWADDR = 32'h08; s_WDATA = new_v; s_WSTRB = 4'hF; s_ARADDR = 32'h08;
    s_AWVALID = 1'b1; s_WVALID = 1'b1; s_ARVALID = 1'b1;
    tick();
    s_AWVALID = 1'b0; s_WVALID = 1'b0; s_ARVALID = 1'b0;
    mdl[2] = new_v;
    check("same_edge_old_value", s_RDATA, old_v);
    check("same_edge_bvalid", s_BVALID, 1);
    check("same_edge_regs", oREG_DATA, exp_flat());
    s_BREADY = 1'b1; s_RREADY = 1'b1;
    tick();
    s_BREADY = 1'b0; s_RREADY = 1'b0;

    for (int n = 0; n < 120; n++) begin
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0;
      for (int s = 1; s < NR; s++) iHW_DATA[s*DW +: DW] = $urandom();
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    new_v = $urandom() | 32'h1;
    s_AWADDR = 32'h14; s_WDATA = new_v; s_WSTRB = 4'hF;
    s_AWVALID = 1'b1; s_WVALID = 1'b1; s_BREADY = 1'b0;
    tick();
    s_AWVALID = 1'b0; s_WVALID = 1'b0;
    mdl[5] = new_v;
    check("hold_bvalid_start", s_BVALID, 1);
    check("hold_regs", oREG_DATA, exp_flat());
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_bvalid", s_BVALID, 1);
      check("hold_bresp", s_BRESP, 2'b00);
      check("hold_ready_low", {s_AWREADY, s_WREADY}, 2'b00);
    end
    #3 iRST = 1'b0;
    #1;
    check("rst_mid_bvalid", s_BVALID, 0);
    check("rst_mid_regs", oREG_DATA, 0);
    check("rst_mid_ready", {s_AWREADY, s_WREADY, s_ARREADY}, 0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    tick();
    iRST = 1'b1;
    tick();
    check("ready_after_rerelease", {s_AWREADY, s_WREADY, s_ARREADY}, 3'b111);
    axi_read(32'h14, 0);
    axi_read(32'h04, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
